// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: bottom-up line-clear and compaction sequencer for the column board RAMs,
// plus a whole-board wipe. Define LINE_CLEAR_SCORE_EN to build the score_add logic.
module line_clear_ctrl #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   clear_all,
  input  logic                   vblank,
  input  logic [COLS*DATA_W-1:0] ram_rdata,
  output logic                   ram_req,
  output logic [ADDR_W-1:0]      ram_row,
  output logic [COLS-1:0]        ram_we,
  output logic [COLS*DATA_W-1:0] ram_wdata,
  output logic                   busy,
  output logic                   done,
  output logic [4:0]             lines_cleared,
  output logic [10:0]            score_add
);

  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WRITE,
    S_FILL,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_W-1:0]      r_rd_row;
  logic [ADDR_W-1:0]      w_rd_nxt;
  logic [ADDR_W-1:0]      r_wr_row;
  logic [ADDR_W-1:0]      w_wr_nxt;
  logic [4:0]             r_count;
  logic [4:0]             w_count_nxt;
  logic [4:0]             r_lines;
  logic [COLS*DATA_W-1:0] r_row_buf;
  logic                   w_row_full;
  logic                   w_buf_ld;
  logic                   w_ram_state;
  logic                   w_wr_phase;
  logic                   w_rd_last;
  logic                   w_pass_go;

  always_comb begin
    w_row_full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (ram_rdata[c*DATA_W +: DATA_W] == '0) w_row_full = 1'b0;
    end
  end

  assign w_rd_last = (r_rd_row == '0);
  assign w_pass_go = (r_state == S_IDLE) && (start || clear_all);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_nxt    = r_rd_row;
    w_wr_nxt    = r_wr_row;
    w_count_nxt = r_count;
    w_buf_ld    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clear_all) begin
          w_state_nxt = S_FILL;
          w_wr_nxt    = ROW_LAST;
          w_count_nxt = '0;
        end else if (start) begin
          w_state_nxt = S_RD_ADDR;
          w_rd_nxt    = ROW_LAST;
          w_wr_nxt    = ROW_LAST;
          w_count_nxt = '0;
        end
      end
      S_RD_ADDR: begin
        if (vblank) w_state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (!vblank) begin
          w_state_nxt = S_RD_ADDR;
        end else if (!w_row_full && (r_rd_row != r_wr_row)) begin
          w_state_nxt = S_WRITE;
          w_buf_ld    = 1'b1;
        end else begin
          if (w_row_full) w_count_nxt = r_count + 5'd1;
          else            w_wr_nxt    = r_wr_row - 1'b1;
          w_rd_nxt = r_rd_row - 1'b1;
          // At the top row a full row still leaves rows to zero; an unmoved one leaves none.
          if (!w_rd_last)      w_state_nxt = S_RD_ADDR;
          else if (w_row_full) w_state_nxt = S_FILL;
          else                 w_state_nxt = S_DONE;
        end
      end
      S_WRITE: begin
        if (vblank) begin
          w_wr_nxt    = r_wr_row - 1'b1;
          w_rd_nxt    = r_rd_row - 1'b1;
          w_state_nxt = w_rd_last ? S_FILL : S_RD_ADDR;
        end
      end
      S_FILL: begin
        if (vblank) begin
          w_wr_nxt = r_wr_row - 1'b1;
          if (r_wr_row == '0) w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rd_row <= ROW_LAST;
      r_wr_row <= ROW_LAST;
      r_count  <= '0;
      r_lines  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rd_row <= w_rd_nxt;
      r_wr_row <= w_wr_nxt;
      r_count  <= w_count_nxt;
      if (w_pass_go)                   r_lines <= '0;
      else if (w_state_nxt == S_DONE)  r_lines <= w_count_nxt;
    end
  end

  // NOTE: the row buffer is pure datapath, always loaded before use, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_buf_ld) r_row_buf <= ram_rdata;
  end

  assign w_ram_state = (r_state == S_RD_ADDR) || (r_state == S_RD_DATA) ||
                       (r_state == S_WRITE)   || (r_state == S_FILL);
  assign w_wr_phase  = (r_state == S_WRITE) || (r_state == S_FILL);

  assign busy          = w_ram_state;
  assign done          = (r_state == S_DONE);
  assign ram_req       = w_ram_state & vblank;
  assign ram_row       = !ram_req ? '0 : (w_wr_phase ? r_wr_row : r_rd_row);
  assign ram_we        = (ram_req && w_wr_phase) ? {COLS{1'b1}} : '0;
  assign ram_wdata     = (ram_req && (r_state == S_WRITE)) ? r_row_buf : '0;
  assign lines_cleared = r_lines;

`ifdef LINE_CLEAR_SCORE_EN
  logic [10:0] r_score;

  function automatic logic [10:0] score_of(input logic [4:0] lines);
    case (lines)
      5'd1:    return 11'd40;
      5'd2:    return 11'd100;
      5'd3:    return 11'd300;
      5'd4:    return 11'd1200;
      default: return 11'd0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_score <= '0;
    else if (w_pass_go)              r_score <= '0;
    else if (w_state_nxt == S_DONE)  r_score <= score_of(w_count_nxt);
  end

  assign score_add = r_score;
`else
  assign score_add = '0;
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: random and directed passes against a compaction model of the board,
// with per-cycle protocol checks on the RAM port.
module tb_line_clear_ctrl;

  localparam int ROWS   = 20;
  localparam int COLS   = 10;
  localparam int DATA_W = 24;
  localparam int ADDR_W = 5;
  localparam int RW     = COLS * DATA_W;
  localparam int BUDGET = 3000;
`ifdef LINE_CLEAR_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif
  localparam logic [RW-1:0] BLUE_ROW = RW'(24'h0000FF) << (3 * DATA_W);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              clear_all;
  logic              vblank;
  logic [RW-1:0]     ram_rdata;
  logic              ram_req;
  logic [ADDR_W-1:0] ram_row;
  logic [COLS-1:0]   ram_we;
  logic [RW-1:0]     ram_wdata;
  logic              busy;
  logic              done;
  logic [4:0]        lines_cleared;
  logic [10:0]       score_add;

  line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear_all(clear_all), .vblank(vblank),
    .ram_rdata(ram_rdata), .ram_req(ram_req), .ram_row(ram_row), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .busy(busy), .done(done), .lines_cleared(lines_cleared),
    .score_add(score_add)
  );

  always #5 clk = ~clk;

  // Board RAM: all ten columns as one wide word per row, synchronous read.
  logic [RW-1:0]     mem [2**ADDR_W];
  logic              tb_ld;
  logic [ADDR_W-1:0] tb_ld_row;
  logic [RW-1:0]     tb_ld_data;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_row];
    if (tb_ld) mem[tb_ld_row] <= tb_ld_data;
    else begin
      for (int c = 0; c < COLS; c++)
        if (ram_we[c]) mem[ram_row][c*DATA_W +: DATA_W] <= ram_wdata[c*DATA_W +: DATA_W];
    end
  end

  int            n_total = 0;
  int            n_bad   = 0;
  int            we_cnt  = 0;
  int            done_cnt = 0;
  int            last_n;
  logic [4:0]    exp_lines_hold;
  logic [10:0]   exp_score_hold;
  logic [RW-1:0] brd      [ROWS];
  logic [RW-1:0] snap     [ROWS];
  logic [RW-1:0] exp_board[ROWS];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we != '0) we_cnt++;
      if (done) done_cnt++;
      if (!vblank) check("vblank_gate", {ram_req, ram_we}, '0);
      if (ram_we != '0) check("we_all_cols", ram_we, {COLS{1'b1}});
      if (!busy) check("idle_no_req", ram_req, 0);
      if (ram_req) check("row_in_range", ram_row >= ADDR_W'(ROWS), 0);
      if (done) check("done_not_busy", busy, 0);
      if (!busy && !start && !clear_all) begin
        check("lines_held", lines_cleared, exp_lines_hold);
        check("score_held", score_add, exp_score_hold);
      end
    end
  end

  function automatic bit row_full(input logic [RW-1:0] r);
    for (int c = 0; c < COLS; c++)
      if (r[c*DATA_W +: DATA_W] == '0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [10:0] score_of(input int k);
    if (!SCORE_EN) return 11'd0;
    case (k)
      1:       return 11'd40;
      2:       return 11'd100;
      3:       return 11'd300;
      4:       return 11'd1200;
      default: return 11'd0;
    endcase
  endfunction

  // kind 0 = empty, 1 = full, 2 = partial (at least one empty cell)
  function automatic logic [RW-1:0] gen_row(input int kind);
    logic [RW-1:0] r;
    int            k;
    r = '0;
    for (int c = 0; c < COLS; c++) begin
      if (kind == 1 || (kind == 2 && $urandom_range(0, 1) == 1))
        r[c*DATA_W +: DATA_W] = DATA_W'($urandom_range(1, 24'hFFFFFF));
    end
    if (kind == 2) begin
      k = $urandom_range(0, COLS - 1);
      r[k*DATA_W +: DATA_W] = '0;
    end
    return r;
  endfunction

  // Expected board: surviving rows slide to the bottom in order, zeros above.
  task automatic model_pass(input bit is_clear, output int fulls, output int lat, output int wes);
    int w;
    int in_place;
    bit seen_full;
    w = ROWS - 1; fulls = 0; in_place = 0; seen_full = 0;
    for (int r = 0; r < ROWS; r++) exp_board[r] = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (row_full(snap[r])) begin
        fulls++;
        seen_full = 1'b1;
      end else begin
        exp_board[w] = snap[r];
        w--;
        if (!seen_full) in_place++;
      end
    end
    wes = (ROWS - fulls - in_place) + fulls;
    lat = 2 * ROWS + wes + 1;
    if (is_clear) begin
      for (int r = 0; r < ROWS; r++) exp_board[r] = '0;
      fulls = 0;
      wes   = ROWS;
      lat   = ROWS + 1;
    end
  endtask

  task automatic load_board();
    for (int r = 0; r < ROWS; r++) begin
      tb_ld = 1'b1; tb_ld_row = ADDR_W'(r); tb_ld_data = brd[r];
      @(posedge clk); #1;
    end
    tb_ld = 1'b0;
  endtask

  // vb_mode 0: vblank held high, 1: random vblank, 2: scripted drops in RD_DATA and WRITE
  task automatic run_pass(input string name, input bit do_start, input bit do_clear,
                          input int vb_mode, input bit stray);
    int fulls, lat, wes, n, we0, d0, low_left;
    bit drop_a, drop_b, we_seen;
    for (int r = 0; r < ROWS; r++) snap[r] = mem[r];
    model_pass(do_clear, fulls, lat, wes);
    exp_lines_hold = 5'(fulls);
    exp_score_hold = score_of(fulls);
    we0 = we_cnt; d0 = done_cnt;
    vblank = 1'b1; start = do_start; clear_all = do_clear;
    @(posedge clk); #1;
    start = 1'b0; clear_all = 1'b0;
    n = 1; low_left = 0; drop_a = 0; drop_b = 0;
    while (!done && n < BUDGET) begin
      we_seen = (ram_we != '0);
      if (vb_mode == 1) vblank = ($urandom_range(0, 3) != 0);
      else if (vb_mode == 2) begin
        if (low_left > 0) begin
          vblank = 1'b0; low_left--;
        end else begin
          vblank = 1'b1;
          if (n == 4 && !drop_a) begin
            drop_a = 1; vblank = 1'b0; low_left = 4;
          end else if (we_seen && drop_a && !drop_b) begin
            drop_b = 1; vblank = 1'b0; low_left = 4;
          end
        end
      end
      start = stray && (n == 5);
      @(posedge clk); #1;
      n++;
    end
    vblank = 1'b1; start = 1'b0;
    last_n = n;
    check($sformatf("%s done_seen", name), done, 1);
    if (vb_mode == 0) check($sformatf("%s latency", name), n, lat);
    if (vb_mode == 2) check($sformatf("%s write_drop_applied", name), drop_b, 1);
    check($sformatf("%s lines", name), lines_cleared, fulls);
    check($sformatf("%s score", name), score_add, score_of(fulls));
    for (int r = 0; r < ROWS; r++)
      check($sformatf("%s row%0d", name, r), mem[r], exp_board[r]);
    check($sformatf("%s we_cycles", name), we_cnt - we0, wes);
    @(posedge clk); #1;
    check($sformatf("%s done_pulses", name), done_cnt - d0, 1);
    check($sformatf("%s back_idle", name), {busy, done}, 0);
  endtask

  initial begin
    int d;
    int n;
    rst_n = 1'b0; start = 1'b0; clear_all = 1'b0; vblank = 1'b0;
    tb_ld = 1'b0; tb_ld_row = '0; tb_ld_data = '0;
    exp_lines_hold = '0; exp_score_hold = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ctrl outputs",
          {busy, done, ram_req, ram_we, ram_row, lines_cleared, score_add}, '0);
    check("reset wdata", ram_wdata, '0);
    rst_n = 1'b1; vblank = 1'b1;
    @(posedge clk); #1;
    check("idle ctrl outputs",
          {busy, done, ram_req, ram_we, ram_row, lines_cleared, score_add}, '0);

    // Empty board
    for (int r = 0; r < ROWS; r++) brd[r] = '0;
    load_board();
    run_pass("t1 empty", 1'b1, 1'b0, 0, 1'b0);
    check("t1 latency literal", last_n, 41);

    // Single full bottom row under a one-cell row
    for (int r = 0; r < ROWS; r++) brd[r] = '0;
    brd[19] = gen_row(1);
    brd[18] = BLUE_ROW;
    load_board();
    run_pass("t2 one line", 1'b1, 1'b0, 0, 1'b0);
    check("t2 lines literal", lines_cleared, 1);
    check("t2 row19 literal", mem[19], BLUE_ROW);
    check("t2 row18 literal", mem[18], '0);
    check("t2 score literal", score_add, SCORE_EN ? 11'd40 : 11'd0);
    check("t2 latency literal", last_n, 61);

    // Four full rows around one partial row
    for (int r = 0; r < ROWS; r++) brd[r] = '0;
    brd[19] = gen_row(1); brd[17] = gen_row(1); brd[16] = gen_row(1); brd[15] = gen_row(1);
    brd[18] = BLUE_ROW;
    load_board();
    run_pass("t3 four lines", 1'b1, 1'b0, 0, 1'b0);
    check("t3 lines literal", lines_cleared, 4);
    check("t3 row19 literal", mem[19], BLUE_ROW);
    check("t3 score literal", score_add, SCORE_EN ? 11'd1200 : 11'd0);

    // vblank drops in RD_DATA and WRITE
    for (int r = 0; r < ROWS; r++) brd[r] = '0;
    brd[19] = gen_row(1);
    brd[18] = BLUE_ROW;
    brd[10] = gen_row(2);
    load_board();
    run_pass("t4 vblank drops", 1'b1, 1'b0, 2, 1'b0);
    check("t4 row19 literal", mem[19], BLUE_ROW);

    // start and clear_all together on a full board, stray start while busy
    for (int r = 0; r < ROWS; r++) brd[r] = gen_row(1);
    load_board();
    run_pass("t5 clear_all", 1'b1, 1'b1, 0, 1'b1);
    check("t5 latency literal", last_n, ROWS + 1);
    d = done_cnt;
    repeat (30) @(posedge clk);
    #1;
    check("t5 no extra pass", done_cnt - d, 0);
    check("t5 still idle", busy, 0);

    // Reset in the middle of a WRITE
    for (int r = 0; r < ROWS; r++) brd[r] = '0;
    brd[19] = gen_row(1);
    for (int r = 0; r < 19; r++) brd[r] = gen_row(2);
    load_board();
    exp_lines_hold = '0; exp_score_hold = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (ram_we == '0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6 write reached", |ram_we, 1);
    rst_n = 1'b0;
    #1;
    check("t6 ctrl in reset",
          {busy, done, ram_req, ram_we, ram_row, lines_cleared, score_add}, '0);
    check("t6 wdata in reset", ram_wdata, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pass("t6 after reset", 1'b1, 1'b0, 0, 1'b0);

    // Random boards, alternating steady and random vblank
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < ROWS; r++) begin
        int k;
        k = $urandom_range(0, 5);
        brd[r] = gen_row((k < 2) ? 1 : (k < 4) ? 2 : 0);
      end
      load_board();
      run_pass($sformatf("rnd%0d", i), 1'b1, (i == 5), i % 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
